// File: rtl/rn_wr_sequencer_if.sv
// Interface: rn_wr_sequencer_if
// Carries the AW/W handshake and payload signals of the RN write sequencer.
// The CPU-side signals are prefixed s_ and the NoC-side signals are prefixed m_.
//   slave  : the sequencer's view. It receives the CPU AW/W requests and the NoC
//            readies, and drives the CPU readies and the NoC valids and W tags.
//   master : the environment's view, which is the mirror of slave.
interface rn_wr_sequencer_if #(
    parameter int unsigned ID_W  = 11,
    parameter int unsigned LEN_W = 8,
    parameter int unsigned TGT_W = 2
) ();
    // AW channel
    logic             s_awvalid;
    logic             s_awready;
    logic [ID_W-1:0]  s_awid;
    logic [LEN_W-1:0] s_awlen;
    logic [TGT_W-1:0] s_awtgt;
    logic             m_awvalid;
    logic             m_awready;
    // W channel
    logic             s_wvalid;
    logic             s_wready;
    logic             s_wlast;
    logic             m_wvalid;
    logic             m_wready;
    logic             m_whead;
    logic             m_wtail;
    logic [TGT_W-1:0] m_wtgtid;
    logic [9:0]       m_wid;

    modport slave (
        input  s_awvalid, s_awid, s_awlen, s_awtgt, m_awready,
        input  s_wvalid, s_wlast, m_wready,
        output s_awready, m_awvalid,
        output s_wready, m_wvalid, m_whead, m_wtail, m_wtgtid, m_wid
    );

    modport master (
        output s_awvalid, s_awid, s_awlen, s_awtgt, m_awready,
        output s_wvalid, s_wlast, m_wready,
        input  s_awready, m_awvalid,
        input  s_wready, m_wvalid, m_whead, m_wtail, m_wtgtid, m_wid
    );
endinterface

// File: rtl/rn_wr_sequencer.sv
// Module: rn_wr_sequencer
// RN-side write sequencer. It queues {id, len, tgt} for each accepted AW request
// and forwards the CPU W beats to the NoC in AW order. Each forwarded beat is
// tagged with head/tail, the target ID and a 10-bit WID taken from the head entry.
// W beats that have no queued AW are blocked, and AW requests that would
// overflow the queue are blocked.
// Ports:
//   clk        clock
//   rst        asynchronous active-low reset
//   bus        AW/W handshake bundle (slave view)
//   occupancy  number of queued AW entries
//   err_wlast  sticky flag, set when WLAST disagrees with the LEN-derived tail
module rn_wr_sequencer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ID_W  = 11,
    parameter int unsigned LEN_W = 8,
    parameter int unsigned TGT_W = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    rn_wr_sequencer_if.slave        bus,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic                    err_wlast
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [9:0]       id_mem  [DEPTH];
    logic [LEN_W-1:0] len_mem [DEPTH];
    logic [TGT_W-1:0] tgt_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LEN_W-1:0] beat_cnt;

    logic full;
    logic empty;
    logic push;
    logic wbeat;
    logic tail;

    // Only AWID[9:0] travels on the NoC as the WID.
    logic unused_id_hi;
    assign unused_id_hi = ^bus.s_awid[ID_W-1:10];

    // The pointers carry one extra wrap bit, so that equal indices with
    // different wrap bits mean full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                   (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
    assign occupancy = wr_ptr - rd_ptr;

    always_comb begin
        bus.m_awvalid = bus.s_awvalid & ~full;
        bus.s_awready = bus.m_awready & ~full;
        push          = bus.m_awvalid & bus.m_awready;

        // The W path looks only at registered queue state, so an entry pushed
        // this cycle cannot be used by W until the next cycle.
        bus.m_wvalid  = bus.s_wvalid & ~empty;
        bus.s_wready  = bus.m_wready & ~empty;
        wbeat         = bus.m_wvalid & bus.m_wready;

        tail          = (beat_cnt == len_mem[rd_ptr[IDX_W-1:0]]);
        bus.m_whead   = (beat_cnt == '0);
        bus.m_wtail   = tail;
        bus.m_wtgtid  = tgt_mem[rd_ptr[IDX_W-1:0]];
        bus.m_wid     = id_mem[rd_ptr[IDX_W-1:0]];
    end

    // The queue storage needs no reset: the pointers decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            id_mem[wr_ptr[IDX_W-1:0]]  <= bus.s_awid[9:0];
            len_mem[wr_ptr[IDX_W-1:0]] <= bus.s_awlen;
            tgt_mem[wr_ptr[IDX_W-1:0]] <= bus.s_awtgt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            beat_cnt  <= '0;
            err_wlast <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (wbeat) begin
                // LEN alone decides the burst boundary. WLAST is only compared against it.
                if (tail) begin
                    beat_cnt <= '0;
                    rd_ptr   <= rd_ptr + PTR_W'(1);
                end else begin
                    beat_cnt <= beat_cnt + LEN_W'(1);
                end
                if (bus.s_wlast != tail) begin
                    err_wlast <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_rn_wr_sequencer.sv
// Testbench: tb_rn_wr_sequencer
// Directed tests of rn_wr_sequencer, with expected values worked out by hand.
// Inputs change 1ns after each rising edge. Outputs are sampled 5ns after the
// edge, which is on the falling edge.
module tb_rn_wr_sequencer;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned ID_W  = 11;
    localparam int unsigned LEN_W = 8;
    localparam int unsigned TGT_W = 2;

    logic clk;
    logic rst;
    logic [$clog2(DEPTH):0] occupancy;
    logic err_wlast;

    int n_checks;
    int n_fail;

    rn_wr_sequencer_if #(.ID_W(ID_W), .LEN_W(LEN_W), .TGT_W(TGT_W)) bus ();

    rn_wr_sequencer #(
        .DEPTH(DEPTH), .ID_W(ID_W), .LEN_W(LEN_W), .TGT_W(TGT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .occupancy (occupancy),
        .err_wlast (err_wlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.s_awvalid = 1'b0;
        bus.s_awid    = '0;
        bus.s_awlen   = '0;
        bus.s_awtgt   = '0;
        bus.m_awready = 1'b0;
        bus.s_wvalid  = 1'b0;
        bus.s_wlast   = 1'b0;
        bus.m_wready  = 1'b0;
    endtask

    // Present one AW and hold it until the handshake completes.
    task automatic aw_push(input logic [ID_W-1:0] id, input logic [LEN_W-1:0] len,
                           input logic [TGT_W-1:0] tgt);
        bit hs;
        hs = 1'b0;
        bus.s_awvalid = 1'b1;
        bus.s_awid    = id;
        bus.s_awlen   = len;
        bus.s_awtgt   = tgt;
        bus.m_awready = 1'b1;
        for (int n = 0; n < 100 && !hs; n++) begin
            #4;
            if (bus.m_awvalid && bus.m_awready) hs = 1'b1;
            next_cycle();
        end
        bus.s_awvalid = 1'b0;
        bus.m_awready = 1'b0;
        if (!hs) check("aw_timeout", 32'(hs), 32'd1);
    endtask

    // Present one W beat and hold it until the handshake completes. The
    // head, tail, target ID and WID are checked on the handshake cycle.
    task automatic w_beat(input string tag, input logic last, input logic exp_head,
                          input logic exp_tail, input logic [TGT_W-1:0] exp_tgt,
                          input logic [9:0] exp_wid);
        bit hs;
        hs = 1'b0;
        bus.s_wvalid = 1'b1;
        bus.s_wlast  = last;
        bus.m_wready = 1'b1;
        for (int n = 0; n < 100 && !hs; n++) begin
            #4;
            if (bus.m_wvalid && bus.m_wready) begin
                hs = 1'b1;
                check({tag, "_head"}, 32'(bus.m_whead), 32'(exp_head));
                check({tag, "_tail"}, 32'(bus.m_wtail), 32'(exp_tail));
                check({tag, "_tgt"}, 32'(bus.m_wtgtid), 32'(exp_tgt));
                check({tag, "_wid"}, 32'(bus.m_wid), 32'(exp_wid));
            end
            next_cycle();
        end
        bus.s_wvalid = 1'b0;
        bus.s_wlast  = 1'b0;
        bus.m_wready = 1'b0;
        if (!hs) check({tag, "_timeout"}, 32'(hs), 32'd1);
    endtask

    // Burst table for the back-to-back run.
    localparam int NB = 10;
    int unsigned t5_len [NB] = '{0, 1, 255, 2, 7, 0, 3, 15, 1, 4};
    int unsigned t5_beats;

    function automatic logic [ID_W-1:0] t5_id(input int i);
        return ID_W'(32'h400 | (i * 37));
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle_inputs();
        rst = 1'b0;
        #12;
        // Reset state, with all inputs idle.
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_err", 32'(err_wlast), 32'd0);
        check("rst_m_awvalid", 32'(bus.m_awvalid), 32'd0);
        check("rst_s_awready", 32'(bus.s_awready), 32'd0);
        check("rst_m_wvalid", 32'(bus.m_wvalid), 32'd0);
        check("rst_s_wready", 32'(bus.s_wready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        next_cycle();

        // T1: a four-beat burst.
        aw_push(11'h005, 8'd3, 2'd2);
        check("t1_occ1", 32'(occupancy), 32'd1);
        w_beat("t1_b1", 1'b0, 1'b1, 1'b0, 2'd2, 10'h005);
        w_beat("t1_b2", 1'b0, 1'b0, 1'b0, 2'd2, 10'h005);
        w_beat("t1_b3", 1'b0, 1'b0, 1'b0, 2'd2, 10'h005);
        w_beat("t1_b4", 1'b1, 1'b0, 1'b1, 2'd2, 10'h005);
        check("t1_occ0", 32'(occupancy), 32'd0);
        check("t1_err", 32'(err_wlast), 32'd0);

        // T2: W presented before any AW, with no same-cycle bypass.
        bus.s_wvalid = 1'b1;
        bus.m_wready = 1'b1;
        bus.s_wlast  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #4;
            check("t2_m_wvalid_blk", 32'(bus.m_wvalid), 32'd0);
            check("t2_s_wready_blk", 32'(bus.s_wready), 32'd0);
            next_cycle();
        end
        bus.s_awvalid = 1'b1;
        bus.m_awready = 1'b1;
        bus.s_awid    = 11'h7ff;
        bus.s_awlen   = 8'd0;
        bus.s_awtgt   = 2'd1;
        #4;
        check("t2_aw_hs", 32'(bus.m_awvalid), 32'd1);
        check("t2_nobypass", 32'(bus.m_wvalid), 32'd0);
        next_cycle();
        bus.s_awvalid = 1'b0;
        bus.m_awready = 1'b0;
        #4;
        check("t2_m_wvalid", 32'(bus.m_wvalid), 32'd1);
        check("t2_s_wready", 32'(bus.s_wready), 32'd1);
        check("t2_wid", 32'(bus.m_wid), 32'h3ff);
        check("t2_head", 32'(bus.m_whead), 32'd1);
        check("t2_tail", 32'(bus.m_wtail), 32'd1);
        next_cycle();
        idle_inputs();
        check("t2_occ0", 32'(occupancy), 32'd0);

        // T3: fill the queue, block the fifth AW, then release it with one pop.
        for (int i = 0; i < 4; i++) aw_push(ID_W'(16 + i), 8'd0, TGT_W'(i));
        check("t3_occ4", 32'(occupancy), 32'd4);
        bus.s_awvalid = 1'b1;
        bus.m_awready = 1'b1;
        bus.s_awid    = 11'h014;
        bus.s_awlen   = 8'd0;
        bus.s_awtgt   = 2'd1;
        #4;
        check("t3_full_s_awready", 32'(bus.s_awready), 32'd0);
        check("t3_full_m_awvalid", 32'(bus.m_awvalid), 32'd0);
        next_cycle();
        bus.s_wvalid = 1'b1;
        bus.m_wready = 1'b1;
        bus.s_wlast  = 1'b1;
        #4;
        check("t3_pop_s_awready", 32'(bus.s_awready), 32'd0);
        check("t3_pop_m_wvalid", 32'(bus.m_wvalid), 32'd1);
        check("t3_pop_wid", 32'(bus.m_wid), 32'h010);
        check("t3_pop_tgt", 32'(bus.m_wtgtid), 32'd0);
        next_cycle();
        bus.s_wvalid = 1'b0;
        bus.m_wready = 1'b0;
        bus.s_wlast  = 1'b0;
        #4;
        check("t3_next_s_awready", 32'(bus.s_awready), 32'd1);
        next_cycle();
        idle_inputs();
        check("t3_occ_refill", 32'(occupancy), 32'd4);
        w_beat("t3_d1", 1'b1, 1'b1, 1'b1, 2'd1, 10'h011);
        w_beat("t3_d2", 1'b1, 1'b1, 1'b1, 2'd2, 10'h012);
        w_beat("t3_d3", 1'b1, 1'b1, 1'b1, 2'd3, 10'h013);
        w_beat("t3_d4", 1'b1, 1'b1, 1'b1, 2'd1, 10'h014);
        check("t3_occ0", 32'(occupancy), 32'd0);

        // T4: a single-beat burst with WLAST missing sets the sticky error.
        aw_push(11'h022, 8'd0, 2'd3);
        w_beat("t4_b", 1'b0, 1'b1, 1'b1, 2'd3, 10'h022);
        check("t4_occ0", 32'(occupancy), 32'd0);
        check("t4_err", 32'(err_wlast), 32'd1);
        repeat (3) next_cycle();
        check("t4_err_held", 32'(err_wlast), 32'd1);

        // T5: back-to-back bursts with random readies, AW and W running concurrently.
        t5_beats = 0;
        fork
            begin
                for (int i = 0; i < NB; i++) begin
                    bit hs;
                    hs = 1'b0;
                    bus.s_awvalid = 1'b1;
                    bus.s_awid    = t5_id(i);
                    bus.s_awlen   = LEN_W'(t5_len[i]);
                    bus.s_awtgt   = TGT_W'(i % 4);
                    for (int n = 0; n < 3000 && !hs; n++) begin
                        bus.m_awready = 1'($urandom_range(0, 1));
                        #4;
                        if (bus.m_awvalid && bus.m_awready) hs = 1'b1;
                        next_cycle();
                    end
                    if (!hs) check("t5_aw_timeout", 32'(hs), 32'd1);
                end
                bus.s_awvalid = 1'b0;
                bus.m_awready = 1'b0;
            end
            begin
                for (int b = 0; b < NB; b++) begin
                    for (int k = 0; k <= int'(t5_len[b]); k++) begin
                        bit hs;
                        hs = 1'b0;
                        bus.s_wvalid = 1'b1;
                        bus.s_wlast  = (k == int'(t5_len[b]));
                        for (int n = 0; n < 300 && !hs; n++) begin
                            bus.m_wready = 1'($urandom_range(0, 1));
                            #4;
                            if (bus.m_wvalid && bus.m_wready) begin
                                hs = 1'b1;
                                if (b == 2) t5_beats++;
                                check("t5_head", 32'(bus.m_whead), 32'(k == 0));
                                check("t5_tail", 32'(bus.m_wtail),
                                      32'(k == int'(t5_len[b])));
                                check("t5_tgt", 32'(bus.m_wtgtid), 32'(b % 4));
                                check("t5_wid", 32'(bus.m_wid), 32'(t5_id(b)) & 32'h3ff);
                            end
                            next_cycle();
                        end
                        if (!hs) check("t5_w_timeout", 32'(hs), 32'd1);
                    end
                end
                bus.s_wvalid = 1'b0;
                bus.s_wlast  = 1'b0;
                bus.m_wready = 1'b0;
            end
        join
        idle_inputs();
        check("t5_len255_beats", t5_beats, 32'd256);
        check("t5_occ0", 32'(occupancy), 32'd0);
        check("t5_err_held", 32'(err_wlast), 32'd1);

        // T6: reset asserted mid-burst.
        aw_push(11'h033, 8'd3, 2'd1);
        w_beat("t6_b1", 1'b0, 1'b1, 1'b0, 2'd1, 10'h033);
        bus.s_wvalid = 1'b1;
        bus.m_wready = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_m_wvalid", 32'(bus.m_wvalid), 32'd0);
        check("t6_rst_s_wready", 32'(bus.s_wready), 32'd0);
        check("t6_rst_occ", 32'(occupancy), 32'd0);
        check("t6_rst_err", 32'(err_wlast), 32'd0);
        idle_inputs();
        next_cycle();
        rst = 1'b1;
        next_cycle();
        aw_push(11'h044, 8'd1, 2'd2);
        w_beat("t6_n1", 1'b0, 1'b1, 1'b0, 2'd2, 10'h044);
        w_beat("t6_n2", 1'b1, 1'b0, 1'b1, 2'd2, 10'h044);
        check("t6_occ0", 32'(occupancy), 32'd0);
        check("t6_err", 32'(err_wlast), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
